// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: operation encodings
// and signed saturation limits.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest result the limit helpers can describe; callers slice down to N.
  localparam int SAT_W_MAX = 256;

  function automatic logic [SAT_W_MAX-1:0] sat_min(input int n);
    logic [SAT_W_MAX-1:0] r;
    r = '0;
    r[0] = 1'b1;
    r = r << (n - 1);
    return r;
  endfunction

  function automatic logic [SAT_W_MAX-1:0] sat_max(input int n);
    return sat_min(n) - 1'b1;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit slice of the rippled adder: registers its sum, the carry out
// of the slice and the carry into the slice's top bit.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             c_top
);

  logic [CHUNK:0]   total_next;
  logic             c_top_next;
  logic [CHUNK-1:0] sum_reg;
  logic             c_out_reg;
  logic             c_top_reg;

  always_comb begin
    total_next = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};
    // Carry into the top bit recovered from that bit's own sum.
    c_top_next = a[CHUNK-1] ^ b[CHUNK-1] ^ total_next[CHUNK-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      c_top_reg <= 1'b0;
    end else if (en) begin
      sum_reg   <= total_next[CHUNK-1:0];
      c_out_reg <= total_next[CHUNK];
      c_top_reg <= c_top_next;
    end
  end

  assign sum   = sum_reg;
  assign c_out = c_out_reg;
  assign c_top = c_top_reg;

endmodule

// File: rtl/addsub_pipe_nbit.sv
// Pipelined N-bit add/subtract with valid/ready handshake, carry rippled one
// CHUNK slice per clock, optional signed saturation and zero/negative flags.
module addsub_pipe_nbit
  import addsub_pkg::*;
#(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         add_n,
  input  logic         sat_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         overflow,
  output logic         zero,
  output logic         neg
);

  localparam int STAGES = N / CHUNK;
  localparam logic [SAT_W_MAX-1:0] SAT_MAX_FULL = sat_max(N);
  localparam logic [SAT_W_MAX-1:0] SAT_MIN_FULL = sat_min(N);
  localparam logic [N-1:0] SAT_MAX = SAT_MAX_FULL[N-1:0];
  localparam logic [N-1:0] SAT_MIN = SAT_MIN_FULL[N-1:0];

  if ((N % CHUNK) != 0 || STAGES < 1) begin : g_bad_cfg
    $error("addsub_pipe_nbit: N must be a non-zero multiple of CHUNK");
  end

  logic             adv;
  logic [N-1:0]     y_eff;
  logic [N-1:0]     s_raw;
  logic [STAGES-1:0] valid_reg;
  logic [1:0]       side_reg [STAGES];  // {sat_en, sign of x}
  logic             carry_w [STAGES];
  logic             c_top_w [STAGES];
  logic             sat_w;
  logic             x_msb_w;

  // Whole pipe advances as one, bubbles included.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign y_eff    = (add_n == OP_ADD) ? y : ~y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < STAGES; i++) side_reg[i] <= '0;
    end else if (adv) begin
      valid_reg[0] <= in_valid;
      side_reg[0]  <= {sat_en, x[N-1]};
      for (int i = 1; i < STAGES; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        side_reg[i]  <= side_reg[i-1];
      end
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [CHUNK-1:0] a_w;
    logic [CHUNK-1:0] b_w;
    logic [CHUNK-1:0] sum_w;
    logic             c_in_w;

    if (gi == 0) begin : g_first
      assign a_w    = x[CHUNK-1:0];
      assign b_w    = y_eff[CHUNK-1:0];
      assign c_in_w = (add_n == OP_SUB);
    end else begin : g_skew
      // Hold this slice's operands back until the carry below it arrives.
      logic [CHUNK-1:0] xd_reg [gi];
      logic [CHUNK-1:0] yd_reg [gi];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < gi; i++) begin
            xd_reg[i] <= '0;
            yd_reg[i] <= '0;
          end
        end else if (adv) begin
          xd_reg[0] <= x[gi*CHUNK +: CHUNK];
          yd_reg[0] <= y_eff[gi*CHUNK +: CHUNK];
          for (int i = 1; i < gi; i++) begin
            xd_reg[i] <= xd_reg[i-1];
            yd_reg[i] <= yd_reg[i-1];
          end
        end
      end

      assign a_w    = xd_reg[gi-1];
      assign b_w    = yd_reg[gi-1];
      assign c_in_w = carry_w[gi-1];
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .a     (a_w),
      .b     (b_w),
      .c_in  (c_in_w),
      .sum   (sum_w),
      .c_out (carry_w[gi]),
      .c_top (c_top_w[gi])
    );

    if (gi == STAGES - 1) begin : g_last
      assign s_raw[gi*CHUNK +: CHUNK] = sum_w;
    end else begin : g_deskew
      localparam int D = STAGES - 1 - gi;
      logic [CHUNK-1:0] rd_reg [D];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) rd_reg[i] <= '0;
        end else if (adv) begin
          rd_reg[0] <= sum_w;
          for (int i = 1; i < D; i++) rd_reg[i] <= rd_reg[i-1];
        end
      end

      assign s_raw[gi*CHUNK +: CHUNK] = rd_reg[D-1];
    end
  end

  assign {sat_w, x_msb_w} = side_reg[STAGES-1];
  assign out_valid        = valid_reg[STAGES-1];
  assign c_out            = carry_w[STAGES-1];
  assign overflow         = c_top_w[STAGES-1] ^ carry_w[STAGES-1];

  always_comb begin
    s = s_raw;
    if (sat_w && overflow) s = x_msb_w ? SAT_MIN : SAT_MAX;
  end

  // Gated by valid so the flag reads 0 out of reset.
  assign zero = out_valid & (s == '0);
  assign neg  = s[N-1];

endmodule

// File: tb/tb_addsub_pipe_nbit.sv
// Scoreboard bench for addsub_pipe_nbit at N=8, CHUNK=4: directed vectors,
// a stalled stream and a mid-flight reset.
module tb_addsub_pipe_nbit;
  import addsub_pkg::*;

  localparam int N     = 8;
  localparam int CHUNK = 4;

  typedef struct packed {
    logic [7:0]  xv;
    logic [7:0]  yv;
    logic        op;
    logic        sat;
    logic [11:0] exp;  // {s, c_out, overflow, zero, neg}
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         add_n = 1'b0;
  logic         sat_en = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] x = '0;
  logic [N-1:0] y = '0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] s;
  logic         c_out;
  logic         overflow;
  logic         zero;
  logic         neg;

  int          checks = 0;
  int          errors = 0;
  int          n_pop = 0;
  int          stall_cnt = 0;
  int          pop_mark;
  logic [11:0] sb_q [$];
  logic [11:0] held;
  logic [11:0] cur;
  logic [11:0] expv;
  bit          held_v = 1'b0;
  vec_t        dir_v [5];
  vec_t        str_v [10];

  always #5 clk = ~clk;

  addsub_pipe_nbit #(.N(N), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .add_n     (add_n),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .overflow  (overflow),
    .zero      (zero),
    .neg       (neg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic send(input vec_t v, input bit track);
    int tries = 0;
    bit done = 1'b0;
    @(negedge clk);
    x = v.xv; y = v.yv; add_n = v.op; sat_en = v.sat; in_valid = 1'b1;
    while (!done) begin
      #1;
      if (in_ready) begin
        if (track) sb_q.push_back(v.exp);
        $display("in  x=%h y=%h op=%0d sat=%0d exp=%h", v.xv, v.yv, v.op, v.sat, v.exp);
        done = 1'b1;
        @(posedge clk);
      end else begin
        tries++;
        if (tries > 50) begin
          checks++; errors++;
          $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required 1");
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", sb_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every transfer, checks hold during stalls.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      cur = {s, c_out, overflow, zero, neg};
      if (out_valid && out_ready) begin
        held_v = 1'b0;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %h, required no beat", cur);
        end else begin
          expv = sb_q.pop_front();
          n_pop++;
          $display("out beat %0d: got %h exp %h", n_pop, cur, expv);
          check("beat", cur, expv);
        end
      end else if (out_valid && !out_ready) begin
        stall_cnt++;
        check("stall_in_ready", in_ready, 0);
        if (held_v) check("stall_hold", cur, held);
        held = cur;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dir_v[0] = '{8'h7F, 8'h01, OP_ADD, 1'b0, {8'h80, 4'b0101}};
    dir_v[1] = '{8'h7F, 8'h01, OP_ADD, 1'b1, {8'h7F, 4'b0100}};
    dir_v[2] = '{8'h00, 8'h01, OP_SUB, 1'b0, {8'hFF, 4'b0001}};
    dir_v[3] = '{8'h05, 8'h05, OP_SUB, 1'b0, {8'h00, 4'b1010}};
    dir_v[4] = '{8'h80, 8'h01, OP_SUB, 1'b1, {8'h80, 4'b1101}};

    str_v[0] = '{8'h12, 8'h34, OP_ADD, 1'b0, {8'h46, 4'b0000}};
    str_v[1] = '{8'hFF, 8'h01, OP_ADD, 1'b0, {8'h00, 4'b1010}};
    str_v[2] = '{8'h40, 8'h40, OP_ADD, 1'b1, {8'h7F, 4'b0100}};
    str_v[3] = '{8'h80, 8'h80, OP_ADD, 1'b0, {8'h00, 4'b1110}};
    str_v[4] = '{8'h80, 8'hFF, OP_ADD, 1'b1, {8'h80, 4'b1101}};
    str_v[5] = '{8'h10, 8'h20, OP_SUB, 1'b0, {8'hF0, 4'b0001}};
    str_v[6] = '{8'h7F, 8'hFF, OP_SUB, 1'b0, {8'h80, 4'b0101}};
    str_v[7] = '{8'h7F, 8'hFF, OP_SUB, 1'b1, {8'h7F, 4'b0100}};
    str_v[8] = '{8'hA5, 8'h5A, OP_SUB, 1'b0, {8'h4B, 4'b1100}};
    str_v[9] = '{8'h3C, 8'hC4, OP_ADD, 1'b1, {8'h00, 4'b1010}};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_flags", {c_out, overflow, zero, neg}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Directed vectors, first one also timed for latency
    send(dir_v[0], 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("latency_early", out_valid, 0);
    @(negedge clk);
    #1;
    check("latency_due", out_valid, 1);
    for (int i = 1; i < 5; i++) send(dir_v[i], 1'b1);
    idle();
    drain();

    // Stream with a 3-cycle consumer stall
    pop_mark = n_pop;
    fork
      begin
        for (int i = 0; i < 10; i++) send(str_v[i], 1'b1);
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", n_pop - pop_mark, 10);
    check("stall_seen", stall_cnt >= 3, 1);

    // Reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    send('{8'h01, 8'h01, OP_ADD, 1'b0, 12'h0}, 1'b0);
    send('{8'h02, 8'h02, OP_ADD, 1'b0, 12'h0}, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("pre_reset_valid", out_valid, 1);
    @(negedge clk);
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_s", s, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    pop_mark = n_pop;
    send('{8'h21, 8'h43, OP_ADD, 1'b0, {8'h64, 4'b0000}}, 1'b1);
    idle();
    drain();
    check("post_reset_count", n_pop - pop_mark, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
